cu_sequencer: RTL and testbench

//  Top-level control sequencer of the multi-cycle CPU. Owns the phase FSM (FETCH/DECODE/EXEC/HALT),

---
 rtl/cu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cu_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// cu_sequencer: phase FSM (FETCH/DECODE/EXEC/HALT) of the multi-cycle CPU.
// Decodes the instruction class in DECODE and routes the matching generator
// control word to the datapath. While a memory wait is pending, the architectural
// write-enables are masked.
// Optional build macro CU_PERF_CNT_EN adds the retired_cnt and stall_cnt counters.
module cu_sequencer #(
  parameter int CUL       = 36,
  parameter int STEP_W    = 4,
  parameter int MAX_STEPS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       IR,
  input  logic [3:0]        status,
  input  logic              mem_ready,
  input  logic [CUL:0]      cw_fetch,
  input  logic [CUL:0]      cw_dpi,
  input  logic [CUL:0]      cw_dpr,
  input  logic [CUL:0]      cw_ls,
  input  logic [CUL:0]      cw_br,
  input  logic              done_dpi,
  input  logic              done_dpr,
  input  logic              done_ls,
  input  logic              done_br,
  output logic [STEP_W-1:0] state,
  output logic [1:0]        phase,
  output logic [CUL:0]      controlWord,
  output logic              stall,
  output logic              halted,
  output logic              illegal
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    PH_FETCH  = 2'b00,
    PH_DECODE = 2'b01,
    PH_EXEC   = 2'b10,
    PH_HALT   = 2'b11
  } phase_t;

  typedef enum logic [2:0] {
    CL_NONE, CL_DPI, CL_DPR, CL_LS, CL_BR, CL_ILLEGAL
  } class_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  phase_t       phase_q;
  class_t       cls_q;
  class_t       dec_cls;
  logic [CUL:0] sel_cw;
  logic         sel_done;
  logic [CUL:0] cw;

  // NZCV is consumed by the generators only
  logic unused_status;
  assign unused_status = ^status;

  assign phase = phase_q;

  // Opcode field classification; earlier patterns take priority over later ones
  function automatic class_t decode_class(input logic [3:0] op);
    casez (op)
      4'b100?: return CL_DPI;
      4'b101?: return CL_BR;
      4'b?101: return CL_DPR;
      4'b?1?0: return CL_LS;
      default: return CL_ILLEGAL;
    endcase
  endfunction

  assign dec_cls = decode_class(IR[28:25]);

  // Select the generator word and its done flag for the latched class
  always_comb begin
    sel_cw   = '0;
    sel_done = 1'b0;
    case (cls_q)
      CL_DPI:  begin sel_cw = cw_dpi; sel_done = done_dpi; end
      CL_DPR:  begin sel_cw = cw_dpr; sel_done = done_dpr; end
      CL_LS:   begin sel_cw = cw_ls;  sel_done = done_ls;  end
      CL_BR:   begin sel_cw = cw_br;  sel_done = done_br;  end
      default: ;
    endcase
  end

  // Memory-wait detection and the outgoing control word, with write-enables masked during a stall
  always_comb begin
    stall = 1'b0;
    cw    = '0;
    case (phase_q)
      PH_FETCH: begin
        cw    = cw_fetch;
        stall = !mem_ready;
      end
      PH_EXEC: begin
        cw    = sel_cw;
        stall = (cls_q == CL_LS) && sel_cw[13] && !mem_ready;
      end
      default: ;
    endcase
    if (stall) begin
      cw[15]  = 1'b0;   // w_reg
      cw[9]   = 1'b0;   // IR_load
      cw[8]   = 1'b0;   // status_load
      cw[1:0] = 2'b00;  // PC_FS
    end
    cw[CUL]     = 1'b0;   // spare bit is never driven high
    controlWord = cw;
  end

  // Phase FSM with the exec step counter, the class latch and the halt flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_FETCH;
      state   <= '0;
      cls_q   <= CL_NONE;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (phase_q)
        PH_FETCH: begin
          if (mem_ready) phase_q <= PH_DECODE;
        end
        PH_DECODE: begin
          state <= '0;
          cls_q <= dec_cls;
          if (IR == 32'hFFFF_FFFF) begin
            phase_q <= PH_HALT;
            halted  <= 1'b1;
          end else if (dec_cls == CL_ILLEGAL) begin
            phase_q <= PH_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            phase_q <= PH_EXEC;
          end
        end
        PH_EXEC: begin
          // a stalled step neither advances nor counts toward the watchdog
          if (!stall) begin
            if (sel_done) begin
              phase_q <= PH_FETCH;
              state   <= '0;
            end else if (state == LAST_STEP) begin
              phase_q <= PH_HALT;
              state   <= '0;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end else begin
              state <= state + STEP_W'(1);
            end
          end
        end
        default: ;  // HALT is left only through reset
      endcase
    end
  end

`ifdef CU_PERF_CNT_EN
  // Performance counters; both wrap naturally at 2^32
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (phase_q == PH_EXEC && !stall && sel_done) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Testbench for cu_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-level reference model.
module tb_cu_sequencer;

  localparam int MAX_STEPS = 8;
  localparam logic [36:0] CLR_STALL = 37'h0_0000_8303;  // w_reg, IR_load, status_load, PC_FS

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR;
  logic [3:0]  status;
  logic        mem_ready;
  logic [36:0] cw_fetch, cw_dpi, cw_dpr, cw_ls, cw_br;
  logic        done_dpi, done_dpr, done_ls, done_br;
  logic [3:0]  state;
  logic [1:0]  phase;
  logic [36:0] controlWord;
  logic        stall, halted, illegal;
`ifdef CU_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  cu_sequencer dut (
    .clock(clock), .reset(reset), .IR(IR), .status(status), .mem_ready(mem_ready),
    .cw_fetch(cw_fetch), .cw_dpi(cw_dpi), .cw_dpr(cw_dpr), .cw_ls(cw_ls), .cw_br(cw_br),
    .done_dpi(done_dpi), .done_dpr(done_dpr), .done_ls(done_ls), .done_br(done_br),
    .state(state), .phase(phase), .controlWord(controlWord), .stall(stall),
    .halted(halted), .illegal(illegal)
`ifdef CU_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  bit cmp_perf = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // classes: 0 none, 1 DPI, 2 DPR, 3 LS, 4 BR, 5 illegal
  int          m_phase, m_step, m_cls;
  bit          m_halted, m_ill;
  int unsigned m_ret, m_stc;

  function automatic int classify(input logic [3:0] op);
    if (op[3] && !op[2] && !op[1]) return 1;
    if (op[3] && !op[2] && op[1])  return 4;
    if (op[2] && !op[1] && op[0])  return 2;
    if (op[2] && !op[0])           return 3;
    return 5;
  endfunction

  function automatic logic [36:0] cls_word();
    case (m_cls)
      1: return cw_dpi;
      2: return cw_dpr;
      3: return cw_ls;
      4: return cw_br;
      default: return '0;
    endcase
  endfunction

  function automatic bit cls_done();
    case (m_cls)
      1: return done_dpi;
      2: return done_dpr;
      3: return done_ls;
      4: return done_br;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_stall();
    if (m_phase == 0) return !mem_ready;
    if (m_phase == 2) return (m_cls == 3) && cw_ls[13] && !mem_ready;
    return 1'b0;
  endfunction

  function automatic logic [36:0] exp_cw();
    logic [36:0] w;
    w = (m_phase == 0) ? cw_fetch : (m_phase == 2) ? cls_word() : 37'h0;
    if (exp_stall()) w = w & ~CLR_STALL;
    w[36] = 1'b0;
    return w;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_step <= 0; m_cls <= 0; m_halted <= 0; m_ill <= 0;
      m_ret <= 0; m_stc <= 0;
    end else begin
      if (exp_stall()) m_stc <= m_stc + 1;
      case (m_phase)
        0: if (mem_ready) m_phase <= 1;
        1: begin
          m_step <= 0;
          if (IR == 32'hFFFF_FFFF) begin
            m_phase <= 3; m_halted <= 1;
          end else if (classify(IR[28:25]) == 5) begin
            m_phase <= 3; m_halted <= 1; m_ill <= 1;
          end else begin
            m_phase <= 2; m_cls <= classify(IR[28:25]);
          end
        end
        2: if (!exp_stall()) begin
          if (cls_done()) begin
            m_phase <= 0; m_step <= 0; m_ret <= m_ret + 1;
          end else if (m_step == MAX_STEPS - 1) begin
            m_phase <= 3; m_halted <= 1; m_ill <= 1;
          end else begin
            m_step <= m_step + 1;
          end
        end
        default: ;
      endcase
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("m_phase", phase, m_phase);
      if (m_phase != 3) chk("m_state", state, m_step);
      chk("m_stall", stall, exp_stall());
      chk("m_cw", controlWord, exp_cw());
      chk("m_halted", halted, m_halted);
      chk("m_illegal", illegal, m_ill);
`ifdef CU_PERF_CNT_EN
      if (cmp_perf) begin
        chk("m_retired", retired_cnt, m_ret);
        chk("m_stallcnt", stall_cnt, m_stc);
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    IR = 32'h0; status = 4'h0; mem_ready = 1'b1;
    cw_fetch = 37'h0_1234_0201; cw_dpi = 37'h0_0ABC_8F0F; cw_dpr = 37'h0_0F00_1111;
    cw_ls = 37'h0_0000_A000; cw_br = 37'h0_5555_0003;
    done_dpi = 0; done_dpr = 0; done_ls = 0; done_br = 0;
  endtask

  task automatic rand_inputs();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    IR = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : {3'($urandom()), op, 25'($urandom())};
    status    = 4'($urandom());
    mem_ready = ($urandom_range(0, 3) != 0);
    cw_fetch  = 37'({$urandom(), $urandom()});
    cw_dpi    = 37'({$urandom(), $urandom()});
    cw_dpr    = 37'({$urandom(), $urandom()});
    cw_ls     = 37'({$urandom(), $urandom()});
    cw_br     = 37'({$urandom(), $urandom()});
    done_dpi  = ($urandom_range(0, 2) == 0);
    done_dpr  = ($urandom_range(0, 2) == 0);
    done_ls   = ($urandom_range(0, 2) == 0);
    done_br   = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    idle_inputs();
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("rst_phase", phase, 2'b00);
    chk("rst_state", state, 4'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;

    // fetch stalled three cycles: IR_load and PC_FS read 0
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fetch_stall", stall, 1'b1);
      chk("fetch_masked_cw", controlWord, 37'h0_1234_0000);
      cyc();
    end
    mem_ready = 1'b1;
    IR = 32'h1000_0000;  // opcode 1000 -> DPI
    #1;
    chk("fetch_pass_stall", stall, 1'b0);
    chk("fetch_pass_cw", controlWord, 37'h0_1234_0201);
    cyc();
    #1;
    chk("decode_phase", phase, 2'b01);
    chk("decode_cw", controlWord, 37'h0);
    cyc();
    IR = 32'h0;  // ignored during EXEC
    #1;
    chk("dpi_s0_phase", phase, 2'b10);
    chk("dpi_s0_state", state, 4'd0);
    chk("dpi_s0_cw", controlWord, 37'h0_0ABC_8F0F);
    cyc();
    done_dpi = 1'b1;
    #1;
    chk("dpi_s1_state", state, 4'd1);
    chk("dpi_s1_cw", controlWord, 37'h0_0ABC_8F0F);
    cyc();
    done_dpi = 1'b0;
    #1;
    chk("dpi_retire_phase", phase, 2'b00);

    // load/store step 1 stalls two cycles
    IR = 32'h0800_0000;  // opcode 0100 -> LS
    cyc();
    cyc();
    #1;
    chk("ls_s0_cw", controlWord, 37'h0_0000_A000);
    cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ls_stall", stall, 1'b1);
      chk("ls_hold_state", state, 4'd1);
      chk("ls_masked_cw", controlWord, 37'h0_0000_2000);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("ls_release_stall", stall, 1'b0);
    chk("ls_release_cw", controlWord, 37'h0_0000_A000);
    cyc();
    #1;
    chk("ls_advance_state", state, 4'd2);
    done_ls = 1'b1;
    cyc();
    done_ls = 1'b0;
    #1;
    chk("ls_retire_phase", phase, 2'b00);

    // illegal opcode halts for good
    IR = 32'h0;
    cyc();
    cyc();
    #1;
    chk("ill_phase", phase, 2'b11);
    chk("ill_halted", halted, 1'b1);
    chk("ill_illegal", illegal, 1'b1);
    chk("ill_cw", controlWord, 37'h0);
    IR = 32'h1000_0000;
    repeat (5) begin
      mem_ready = ~mem_ready;
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("ill_stays", phase, 2'b11);

    // all-ones instruction halts cleanly
    pulse_reset();
    IR = 32'hFFFF_FFFF;
    cyc();
    cyc();
    #1;
    chk("hlt_phase", phase, 2'b11);
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_illegal", illegal, 1'b0);

    // watchdog: DPR never signals done
    pulse_reset();
    IR = 32'h0A00_0000;  // opcode 0101 -> DPR
    cyc();
    cyc();
    repeat (7) cyc();
    #1;
    chk("wd_last_state", state, 4'd7);
    chk("wd_last_phase", phase, 2'b10);
    cyc();
    #1;
    chk("wd_phase", phase, 2'b11);
    chk("wd_illegal", illegal, 1'b1);

    // reset in the middle of EXEC step 2
    pulse_reset();
    IR = 32'h1000_0000;
    repeat (4) cyc();
    #1;
    chk("mid_state", state, 4'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_phase", phase, 2'b00);
    chk("mid_rst_state", state, 4'd0);
    cyc();
    chk("mid_rst_halted", halted, 1'b0);
    chk("mid_rst_cw", controlWord, 37'h0_1234_0201);
    reset = 1'b0;

`ifdef CU_PERF_CNT_EN
    // five DPI instructions, four of them with one fetch stall
    pulse_reset();
    IR = 32'h1000_0000;
    done_dpi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        mem_ready = 1'b0;
        cyc();
        mem_ready = 1'b1;
      end
      repeat (3) cyc();
    end
    done_dpi = 1'b0;
    #1;
    chk("perf_retired", retired_cnt, 32'd5);
    chk("perf_stalls", stall_cnt, 32'd4);
    cmp_perf = 1'b0;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    mem_ready = 1'b0;
    cyc();
    mem_ready = 1'b1;
    #1;
    chk("perf_wrap", stall_cnt, 32'd0);
    pulse_reset();
    cmp_perf = 1'b1;
`endif

    // randomized traffic
    for (int s = 0; s < 30; s++) begin
      pulse_reset();
      for (int c = 0; c < 50; c++) begin
        rand_inputs();
        reset = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 2) == 0);
        cyc();
      end
    end
    reset = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
